// File: rtl/ext_mem_arbiter.sv
// Arbitrates the external SRAM bus between VGA glyph fetch and CPU load/store.
// VGA has priority; a CPU request is forced through after STARVE_LIMIT straight VGA grants.
module ext_mem_arbiter #(
    parameter int DW           = 16,
    parameter int AW           = 16,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic [DW-1:0] mem_din,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] EXT_MEM_ADDR,
    output logic [DW-1:0] DOUT_SRAM,
    output logic          dout_en,
    output logic          CE,
    output logic          OE,
    output logic          WE,
    output logic          grant_vga,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic [3:0] starve_cnt;
    logic       is_write;
    logic       pick_cpu;

    function automatic logic [3:0] starve_inc(input logic [3:0] v);
        return (v >= 4'(STARVE_LIMIT)) ? 4'(STARVE_LIMIT) : v + 4'd1;
    endfunction

    // CPU wins when VGA is idle or the CPU has waited out STARVE_LIMIT VGA grants.
    assign pick_cpu = cpu_req && (!vga_req || (starve_cnt == 4'(STARVE_LIMIT)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            starve_cnt   <= '0;
            is_write     <= 1'b0;
            vga_ack      <= 1'b0;
            cpu_ack      <= 1'b0;
            rdata        <= '0;
            EXT_MEM_ADDR <= '0;
            DOUT_SRAM    <= '0;
            dout_en      <= 1'b0;
            CE           <= 1'b1;
            OE           <= 1'b1;
            WE           <= 1'b1;
            grant_vga    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            vga_ack <= 1'b0;
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (vga_req || cpu_req) begin
                        grant_vga    <= !pick_cpu;
                        is_write     <= pick_cpu && cpu_we;
                        EXT_MEM_ADDR <= pick_cpu ? cpu_addr : vga_addr;
                        if (pick_cpu) begin
                            DOUT_SRAM <= cpu_wdata;
                        end
                        starve_cnt   <= (!pick_cpu && cpu_req) ? starve_inc(starve_cnt) : 4'd0;
                        dout_en      <= pick_cpu && cpu_we;
                        CE           <= 1'b0;
                        busy         <= 1'b1;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    OE       <= is_write;
                    WE       <= !is_write;
                    wait_cnt <= 4'(WAIT_CYCLES - 1);
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        CE      <= 1'b1;
                        OE      <= 1'b1;
                        WE      <= 1'b1;
                        dout_en <= 1'b0;
                        if (!is_write) begin
                            rdata <= mem_din;
                        end
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    // Address and write data stay put here to give the SRAM one cycle of hold.
                    vga_ack   <= grant_vga;
                    cpu_ack   <= !grant_vga;
                    grant_vga <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
